// File: rtl/branch_target_pkg.sv
// Default widths and the page-index helper for the branch target calculator.
// Optional build macro BTC_PC_PLUS4_EN lives in branch_target_calculator.sv.
package branch_target_pkg;

  localparam int PC_WIDTH  = 32;
  localparam int IMM_WIDTH = 16;
  localparam int BT_WIDTH  = 8;
  localparam int SHIFT     = 2;

  // Page number of an address, zero-extended to 64 bits.
  function automatic logic [63:0] page_index(
    input logic [63:0] addr,
    input int unsigned lsb
  );
    return addr >> lsb;
  endfunction

endpackage

// File: rtl/branch_target_calculator_sign_extender.sv
// Combinational sign extension from IN_WIDTH to OUT_WIDTH bits.
// Requires OUT_WIDTH > IN_WIDTH.
module sign_extender #(
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = 32
) (
  input  logic [IN_WIDTH-1:0]  value,
  output logic [OUT_WIDTH-1:0] extended
);

  assign extended = {{(OUT_WIDTH-IN_WIDTH){value[IN_WIDTH-1]}}, value};

endmodule

// File: rtl/branch_target_calculator.sv
// Registered PC-relative branch target: word index BT plus page-crossing flag.
// Define BTC_PC_PLUS4_EN to use PC + (1 << SHIFT) as the branch base.
module branch_target_calculator #(
  parameter int PC_WIDTH  = branch_target_pkg::PC_WIDTH,
  parameter int IMM_WIDTH = branch_target_pkg::IMM_WIDTH,
  parameter int BT_WIDTH  = branch_target_pkg::BT_WIDTH,
  parameter int SHIFT     = branch_target_pkg::SHIFT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [IMM_WIDTH-1:0] immediate,
  input  logic [PC_WIDTH-1:0]  program_counter,
  output logic [BT_WIDTH-1:0]  BT,
  output logic                 out_valid,
  output logic                 out_of_range
);

  import branch_target_pkg::*;

  localparam int unsigned PAGE_LSB = BT_WIDTH + SHIFT;

  logic [PC_WIDTH-1:0] sext;
  logic [PC_WIDTH-1:0] off;
  logic [PC_WIDTH-1:0] base;
  logic [PC_WIDTH-1:0] target;
  logic [BT_WIDTH-1:0] bt_next;
  logic                oor_next;

  sign_extender #(
    .IN_WIDTH (IMM_WIDTH),
    .OUT_WIDTH(PC_WIDTH)
  ) u_sext (
    .value   (immediate),
    .extended(sext)
  );

  assign off = sext << SHIFT;

`ifdef BTC_PC_PLUS4_EN
  assign base = program_counter + PC_WIDTH'(1 << SHIFT);
`else
  assign base = program_counter;
`endif

  // Wrap-around of the sum is intentional and silent.
  assign target  = base + off;
  assign bt_next = target[PAGE_LSB-1:SHIFT];

  assign oor_next =
    page_index(64'(target), PAGE_LSB) !=
    page_index(64'(base), PAGE_LSB);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      BT           <= '0;
      out_valid    <= 1'b0;
      out_of_range <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        BT           <= bt_next;
        out_of_range <= oor_next;
      end
    end
  end

endmodule

// File: tb/tb_branch_target_calculator.sv
// Self-checking bench: directed table, reset/handshake sequences, random run.
// Follows the BTC_PC_PLUS4_EN build of the design when defined.
module tb_branch_target_calculator;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [15:0] immediate;
  logic [31:0] program_counter;
  logic [7:0]  BT;
  logic        out_valid;
  logic        out_of_range;

  int n_checks;
  int n_fail;

  branch_target_calculator dut (
    .clk            (clk),
    .reset          (reset),
    .in_valid       (in_valid),
    .immediate      (immediate),
    .program_counter(program_counter),
    .BT             (BT),
    .out_valid      (out_valid),
    .out_of_range   (out_of_range)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] pc;
    logic [15:0] imm;
    logic [7:0]  bt;
    logic        oor;
  } vec_t;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on byte addresses.
  task automatic model(input logic [31:0] pc,
                       input logic [15:0] imm,
                       output logic [7:0] bt,
                       output logic oor);
    longint b;
    longint t;
    b = longint'(pc);
`ifdef BTC_PC_PLUS4_EN
    b = (b + 4) & 64'hFFFF_FFFF;
`endif
    t = (b + 4 * longint'($signed(imm))) & 64'hFFFF_FFFF;
    bt  = 8'((t / 4) % 256);
    oor = (t / 1024) != (b / 1024);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[$];
  logic [7:0] e_bt;
  logic       e_oor;
  logic       e_ov;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset = 1'b1;
    in_valid = 1'b0;
    immediate = '0;
    program_counter = '0;

`ifdef BTC_PC_PLUS4_EN
    vecs.push_back('{32'h8000_0004, 16'hFFFF, 8'h01, 1'b0});
    vecs.push_back('{32'h8000_03FC, 16'h0000, 8'h00, 1'b0});
`else
    vecs.push_back('{32'h8000_0000, 16'h1234, 8'h34, 1'b1});
    vecs.push_back('{32'h8000_000C, 16'h0000, 8'h03, 1'b0});
    vecs.push_back('{32'h8000_0004, 16'hFFFF, 8'h00, 1'b0});
    vecs.push_back('{32'h8000_0008, 16'h7FFF, 8'h01, 1'b1});
    vecs.push_back('{32'h8000_0010, 16'h8000, 8'h04, 1'b1});
    vecs.push_back('{32'h0000_0000, 16'hFFFF, 8'hFF, 1'b1});
`endif

    // Reset state
    tick();
    tick();
    check("reset_bt", 32'(BT), 32'h0);
    check("reset_ov", 32'(out_valid), 32'h0);
    check("reset_oor", 32'(out_of_range), 32'h0);

    // Load a non-zero result, then reset asynchronously mid-cycle
    reset = 1'b0;
    tick();
    in_valid = 1'b1;
    program_counter = 32'h8000_0008;
    immediate = 16'h7FFF;
    tick();
    in_valid = 1'b0;
    check("pre_async_ov", 32'(out_valid), 32'h1);
    #2;
    reset = 1'b1;
    #1;
    check("async_bt", 32'(BT), 32'h0);
    check("async_ov", 32'(out_valid), 32'h0);
    check("async_oor", 32'(out_of_range), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    tick();
    tick();
    check("post_rst_bt", 32'(BT), 32'h0);
    check("post_rst_ov", 32'(out_valid), 32'h0);
    check("post_rst_oor", 32'(out_of_range), 32'h0);

    // Request in flight when reset hits is discarded
    in_valid = 1'b1;
    program_counter = 32'h0000_0000;
    immediate = 16'hFFFF;
    reset = 1'b1;
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    tick();
    check("discard_ov", 32'(out_valid), 32'h0);
    check("discard_bt", 32'(BT), 32'h0);

    // Directed table
    foreach (vecs[i]) begin
      in_valid = 1'b1;
      program_counter = vecs[i].pc;
      immediate = vecs[i].imm;
      tick();
      in_valid = 1'b0;
      check($sformatf("vec%0d_ov", i), 32'(out_valid), 32'h1);
      check($sformatf("vec%0d_bt", i), 32'(BT), 32'(vecs[i].bt));
      check($sformatf("vec%0d_oor", i), 32'(out_of_range),
            32'(vecs[i].oor));
      tick();
      check($sformatf("vec%0d_idle_ov", i), 32'(out_valid), 32'h0);
    end

    // Three back-to-back requests, then idle with hold
    begin
      logic [31:0] pcs[3];
      logic [15:0] imms[3];
      pcs[0] = 32'h8000_0004; imms[0] = 16'hFFFF;
      pcs[1] = 32'h8000_0000; imms[1] = 16'h1234;
      pcs[2] = 32'h8000_000C; imms[2] = 16'h0000;
      for (int i = 0; i < 3; i++) begin
        in_valid = 1'b1;
        program_counter = pcs[i];
        immediate = imms[i];
        tick();
        model(pcs[i], imms[i], e_bt, e_oor);
        check($sformatf("b2b%0d_ov", i), 32'(out_valid), 32'h1);
        check($sformatf("b2b%0d_bt", i), 32'(BT), 32'(e_bt));
        check($sformatf("b2b%0d_oor", i), 32'(out_of_range), 32'(e_oor));
      end
      in_valid = 1'b0;
      program_counter = 32'h0000_0000;
      immediate = 16'hFFFF;
      tick();
      check("b2b_idle_ov", 32'(out_valid), 32'h0);
      check("b2b_hold_bt", 32'(BT), 32'(e_bt));
      check("b2b_hold_oor", 32'(out_of_range), 32'(e_oor));
      tick();
      check("b2b_hold2_bt", 32'(BT), 32'(e_bt));
    end

    // Random run against the reference
    e_ov = 1'b0;
    for (int n = 0; n < 400; n++) begin
      logic        v;
      logic [31:0] pc;
      logic [15:0] imm;
      v = ($urandom_range(0, 9) < 7);
      case ($urandom_range(0, 3))
        0: pc = 32'($urandom_range(0, 16)) << 2;
        1: pc = 32'hFFFF_FFFF - 32'($urandom_range(0, 64));
        default: pc = $urandom;
      endcase
      case ($urandom_range(0, 3))
        0: imm = 16'h8000 + 16'($urandom_range(0, 3));
        1: imm = 16'h7FFF - 16'($urandom_range(0, 3));
        default: imm = 16'($urandom);
      endcase
      in_valid = v;
      program_counter = pc;
      immediate = imm;
      tick();
      if (v) model(pc, imm, e_bt, e_oor);
      e_ov = v;
      check($sformatf("rnd%0d_ov", n), 32'(out_valid), 32'(e_ov));
      check($sformatf("rnd%0d_bt", n), 32'(BT), 32'(e_bt));
      check($sformatf("rnd%0d_oor", n), 32'(out_of_range), 32'(e_oor));
    end
    in_valid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_target_calculator.md
Name: branch_target_calculator

Overview:
Computes the branch target for a PC-relative branch. The target is formed from the current program counter and a signed 16-bit immediate, which is a word offset. The block returns an 8-bit word index into instruction memory, BT, plus a page-crossing flag. It sits in the fetch/decode path between the decoder's immediate field and the PC-select mux, and its result is registered.

Parameters:
PC_WIDTH, 32, width of program_counter and of the internal target sum
IMM_WIDTH, 16, width of the signed immediate
BT_WIDTH, 8, width of the BT word index
SHIFT, 2, left shift applied to the immediate (log2 of bytes per instruction word)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
in_valid  input  1  request strobe; inputs are sampled only when high
immediate  input  IMM_WIDTH  signed word offset
program_counter  input  PC_WIDTH  byte address of the branch instruction
BT  output  BT_WIDTH  registered target word index
out_valid  output  1  one-cycle pulse: BT and out_of_range were updated this cycle
out_of_range  output  1  registered flag: target lies outside the current 2^(BT_WIDTH+SHIFT)-byte page

Behaviour:
- Interface: single clock clk; reset is asynchronous and active-high.
- While reset is high: BT=0, out_valid=0, out_of_range=0. The registers clear immediately, without waiting for a clock edge.
- Sign extension: sext = immediate sign-extended from IMM_WIDTH to PC_WIDTH.
- Offset: off = sext << SHIFT, truncated to PC_WIDTH.
- Base: base = program_counter.
- Target: target = (base + off) mod 2^PC_WIDTH. Wrap-around is silent; there is no carry or overflow output.
- BT = target[BT_WIDTH+SHIFT-1 : SHIFT].
- out_of_range = (target[PC_WIDTH-1 : BT_WIDTH+SHIFT] != base[PC_WIDTH-1 : BT_WIDTH+SHIFT]).
- Latency is exactly 1 cycle. On the rising edge where in_valid=1, BT and out_of_range load, and out_valid=1 in the following cycle.
- With in_valid=0, out_valid goes to 0 and BT and out_of_range hold their last values.
- Back-to-back requests are accepted every cycle; throughput is 1 per cycle. There is no backpressure.
- If reset asserts mid-operation, any pending result is discarded and out_valid is 0 on the first edge after reset deasserts.
- program_counter low SHIFT bits are not checked. They pass into the sum unchanged and are dropped by the BT slice.
- The add path is purely combinational from the sampled inputs into a single register stage. It contains no latches.

Optional Feature:
Macro BTC_PC_PLUS4_EN.
- Defined: base = program_counter + (1 << SHIFT), i.e. PC+4. The out_of_range comparison uses this base.
- Undefined: base = program_counter.
- All other behaviour is identical in both builds.

Decomposition:
- Package branch_target_pkg holds the default width constants (PC_WIDTH, IMM_WIDTH, BT_WIDTH, SHIFT) and a function for the page-index slice.
- One natural sub-module, sign_extender, which is parameterised in and out width and combinational.
- The adder, the page comparator and the output register stay in the top module.

Test Plan:
1. Reset: assert reset asynchronously mid-cycle -> BT=0x00, out_valid=0, out_of_range=0 immediately; after release with in_valid=0, outputs stay at 0.
2. Positive offset: PC=0x80000000, imm=0x1234, in_valid 1 cycle -> next cycle out_valid=1, BT=0x34, out_of_range=1. Zero offset: PC=0x8000000C, imm=0x0000 -> BT=0x03, out_of_range=0.
3. Negative and extreme offsets, each -> BT, out_of_range:
   - PC=0x80000004, imm=0xFFFF -> BT=0x00, out_of_range=0.
   - PC=0x80000008, imm=0x7FFF -> BT=0x01, out_of_range=1.
   - PC=0x80000010, imm=0x8000 -> BT=0x04, out_of_range=1.
4. Wrap-around: PC=0x00000000, imm=0xFFFF -> target 0xFFFFFFFC, BT=0xFF, out_of_range=1, with no other error indication.
5. Handshake: three back-to-back valid requests (the vectors of scenario 2 and PC=0x80000004/imm=0xFFFF) -> out_valid high for 3 consecutive cycles, each result 1 cycle after its request. Then in_valid=0 -> out_valid=0, BT holds the last value.
6. BTC_PC_PLUS4_EN build: PC=0x80000004, imm=0xFFFF -> BT=0x01, out_of_range=0. PC=0x800003FC, imm=0x0000 -> BT=0x00, out_of_range=0, because base 0x80000400 and target share a page.
